// File: rtl/pq_dequeue_interface.sv
// Bus-read front end for a priority queue: one dequeue per request, timeout error response.
// Optional PQ_EMPTY_RESP_EN: answer requests against an empty queue with an all-ones/rempty response.
module pq_dequeue_interface #(
    parameter int KW = 8,
    parameter int VW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rreq_in,
    input  logic             rrdy_in,
    output logic [KW+VW-1:0] rdata_out,
    output logic             rvalid_out,
    output logic             rerr_out,
    output logic             rempty_out,
    input  logic             pq_rdy_in,
    input  logic             pq_empty_in,
    output logic             pq_deq_out,
    input  logic [KW+VW-1:0] pq_data_in,
    input  logic             pq_valid_in,
    output logic [1:0]       state_out
);
    // state     | meaning
    // S_IDLE    | waiting for a bus read request
    // S_PQWAIT  | request accepted, queue not ready for a dequeue
    // S_CAPTURE | dequeue strobed, waiting for pq_valid_in or timeout
    // S_PRESENT | response on the bus until rrdy_in
    localparam int W = KW + VW;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PQWAIT  = 2'd1,
        S_CAPTURE = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    state_t       state, state_nxt;
    logic [W-1:0] rdata_nxt;
    logic         rvalid_nxt, rerr_nxt, rempty_nxt, deq_nxt;
    logic [3:0]   tmo_cnt, tmo_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rdata_out  <= '0;
            rvalid_out <= 1'b0;
            rerr_out   <= 1'b0;
            rempty_out <= 1'b0;
            pq_deq_out <= 1'b0;
            tmo_cnt    <= 4'd0;
        end else begin
            state      <= state_nxt;
            rdata_out  <= rdata_nxt;
            rvalid_out <= rvalid_nxt;
            rerr_out   <= rerr_nxt;
            rempty_out <= rempty_nxt;
            pq_deq_out <= deq_nxt;
            tmo_cnt    <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rdata_nxt  = rdata_out;
        rvalid_nxt = rvalid_out;
        rerr_nxt   = rerr_out;
        rempty_nxt = rempty_out;
        deq_nxt    = 1'b0;
        tmo_nxt    = tmo_cnt;
        case (state)
            S_IDLE: begin
                rdata_nxt  = '0;
                rvalid_nxt = 1'b0;
                rerr_nxt   = 1'b0;
                rempty_nxt = 1'b0;
                if (rreq_in) begin
                    if (!pq_empty_in) begin
                        if (pq_rdy_in) begin
                            deq_nxt   = 1'b1;
                            tmo_nxt   = 4'd0;
                            state_nxt = S_CAPTURE;
                        end else begin
                            state_nxt = S_PQWAIT;
                        end
                    end
`ifdef PQ_EMPTY_RESP_EN
                    else begin
                        rdata_nxt  = '1;
                        rempty_nxt = 1'b1;
                        rvalid_nxt = 1'b1;
                        state_nxt  = S_PRESENT;
                    end
`endif
                end
            end
            S_PQWAIT: begin
                if (pq_rdy_in) begin
                    deq_nxt   = 1'b1;
                    tmo_nxt   = 4'd0;
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (pq_valid_in) begin
                    rdata_nxt  = pq_data_in;
                    rerr_nxt   = 1'b0;
                    rvalid_nxt = 1'b1;
                    state_nxt  = S_PRESENT;
                end else if (tmo_cnt == 4'd14) begin
                    // this is the 15th cycle without data; the count reaches 15 on exit
                    tmo_nxt    = 4'd15;
                    rdata_nxt  = '0;
                    rerr_nxt   = 1'b1;
                    rvalid_nxt = 1'b1;
                    state_nxt  = S_PRESENT;
                end else begin
                    tmo_nxt = tmo_cnt + 4'd1;
                end
            end
            S_PRESENT: begin
                if (rrdy_in) begin
                    rdata_nxt  = '0;
                    rvalid_nxt = 1'b0;
                    rerr_nxt   = 1'b0;
                    rempty_nxt = 1'b0;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign state_out = state;

endmodule

// File: tb/tb_pq_dequeue_interface.sv
// Scoreboard bench for pq_dequeue_interface; honours PQ_EMPTY_RESP_EN like the design.
module tb_pq_dequeue_interface;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst, rreq_in, rrdy_in, pq_rdy_in, pq_empty_in, pq_valid_in;
    logic [W-1:0] pq_data_in, rdata_out;
    logic         rvalid_out, rerr_out, rempty_out, pq_deq_out;
    logic [1:0]   state_out;

    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
        logic         empty;
    } resp_t;

    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    deq_cnt  = 0;

    pq_dequeue_interface #(.KW(8), .VW(4)) dut (
        .clk(clk), .rst(rst), .rreq_in(rreq_in), .rrdy_in(rrdy_in),
        .rdata_out(rdata_out), .rvalid_out(rvalid_out), .rerr_out(rerr_out),
        .rempty_out(rempty_out), .pq_rdy_in(pq_rdy_in), .pq_empty_in(pq_empty_in),
        .pq_deq_out(pq_deq_out), .pq_data_in(pq_data_in), .pq_valid_in(pq_valid_in),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_state"}, 32'(state_out), 32'd0);
        chk({tag, "_outs"}, {rdata_out, rvalid_out, rerr_out, rempty_out, pq_deq_out}, 32'd0);
    endtask

    // response monitor: pops the scoreboard on every bus handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (pq_deq_out) deq_cnt++;
            if (rvalid_out && rrdy_in) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    resp_t e;
                    e = exp_q.pop_front();
                    chk("sb_data", 32'(rdata_out), 32'(e.data));
                    chk("sb_err", 32'(rerr_out), 32'(e.err));
                    chk("sb_empty", 32'(rempty_out), 32'(e.empty));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, cap;
        rst = 1'b1; rreq_in = 0; rrdy_in = 0; pq_rdy_in = 0; pq_empty_in = 0;
        pq_valid_in = 0; pq_data_in = '0;
        tick(); tick();
        idle_outputs("reset");
        rst = 1'b0;
        tick();

        // basic read, data returned in strobe cycle
        d0 = deq_cnt;
        rreq_in = 1; pq_rdy_in = 1; rrdy_in = 1;
        exp_q.push_back('{12'hA53, 1'b0, 1'b0});
        tick();
        chk("a_state_cap", 32'(state_out), 32'd2);
        chk("a_deq", 32'(pq_deq_out), 32'd1);
        chk("a_rvalid_early", 32'(rvalid_out), 32'd0);
        rreq_in = 0; pq_valid_in = 1; pq_data_in = 12'hA53;
        tick();
        chk("a_rvalid_lat2", 32'(rvalid_out), 32'd1);
        chk("a_rdata", 32'(rdata_out), 32'hA53);
        chk("a_deq_off", 32'(pq_deq_out), 32'd0);
        pq_valid_in = 0;
        tick();
        idle_outputs("a_idle");
        chk("a_deq_pulses", 32'(deq_cnt - d0), 32'd1);

        // queue not ready for five cycles
        d0 = deq_cnt;
        rreq_in = 1; pq_rdy_in = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_pqwait", 32'(state_out), 32'd1);
            chk("b_no_deq", 32'(pq_deq_out), 32'd0);
        end
        pq_rdy_in = 1;
        tick();
        chk("b_deq", 32'(pq_deq_out), 32'd1);
        rreq_in = 0; pq_valid_in = 1; pq_data_in = 12'h5C3;
        exp_q.push_back('{12'h5C3, 1'b0, 1'b0});
        tick();
        pq_valid_in = 0;
        tick();
        chk("b_deq_pulses", 32'(deq_cnt - d0), 32'd1);

        // bus back-pressure with changing queue data
        rrdy_in = 0; rreq_in = 1;
        tick();
        rreq_in = 0; pq_valid_in = 1; pq_data_in = 12'h3B7;
        exp_q.push_back('{12'h3B7, 1'b0, 1'b0});
        tick();
        for (int i = 0; i < 4; i++) begin
            pq_data_in = 12'($urandom);
            pq_valid_in = 1'($urandom);
            tick();
            chk("c_hold_data", 32'(rdata_out), 32'h3B7);
            chk("c_hold_valid", 32'(rvalid_out), 32'd1);
        end
        pq_valid_in = 0;
        rrdy_in = 1;
        tick();
        idle_outputs("c_idle");

        // timeout: no pq_valid_in
        rrdy_in = 0; rreq_in = 1;
        tick();
        rreq_in = 0;
        cap = 0;
        while (state_out == 2'd2 && cap < 40) begin
            cap++;
            tick();
        end
        chk("d_capture_cycles", 32'(cap), 32'd15);
        chk("d_rvalid", 32'(rvalid_out), 32'd1);
        chk("d_rerr", 32'(rerr_out), 32'd1);
        chk("d_rdata", 32'(rdata_out), 32'd0);
        exp_q.push_back('{12'h000, 1'b1, 1'b0});
        pq_valid_in = 1; pq_data_in = 12'hFFE;
        tick(); tick();
        chk("d_late_ignored", 32'(rdata_out), 32'd0);
        rrdy_in = 1;
        tick();
        tick();
        idle_outputs("d_idle_late");
        pq_valid_in = 0;

        // request against an empty queue
        d0 = deq_cnt;
        rreq_in = 1; pq_empty_in = 1;
`ifdef PQ_EMPTY_RESP_EN
        exp_q.push_back('{12'hFFF, 1'b0, 1'b1});
        tick();
        chk("e_state", 32'(state_out), 32'd3);
        chk("e_rdata", 32'(rdata_out), 32'hFFF);
        chk("e_rempty", 32'(rempty_out), 32'd1);
        rreq_in = 0;
        tick();
        chk("e_no_deq", 32'(deq_cnt - d0), 32'd0);
`else
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("e_stall", 32'(state_out), 32'd0);
            chk("e_no_rvalid", 32'(rvalid_out), 32'd0);
        end
        chk("e_no_deq", 32'(deq_cnt - d0), 32'd0);
        pq_empty_in = 0;
        tick();
        chk("e_deq", 32'(pq_deq_out), 32'd1);
        rreq_in = 0; pq_valid_in = 1; pq_data_in = 12'h1E4;
        exp_q.push_back('{12'h1E4, 1'b0, 1'b0});
        tick();
        chk("e_rempty_zero", 32'(rempty_out), 32'd0);
        pq_valid_in = 0;
        tick();
`endif
        pq_empty_in = 0;
        tick();

        // reset in CAPTURE abandons the response
        rreq_in = 1; rrdy_in = 0;
        tick();
        chk("f_state_cap", 32'(state_out), 32'd2);
        rreq_in = 0; rst = 1;
        tick();
        idle_outputs("f_reset");
        rst = 0;
        d0 = deq_cnt;
        tick(); tick(); tick();
        chk("f_no_rerequest", 32'(deq_cnt - d0), 32'd0);
        chk("f_still_idle", 32'(state_out), 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
